// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit: valid/ready register slices, pass-through tag.
// Build option BSH_SRA_EN: op 11 becomes an arithmetic right shift.
module pipelined_barrel_shifter #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int TAG_W            = 4,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int NLEV    = SHAMT_W,
  localparam int LAT     =
    (NLEV + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_SRX = 2'b11;

  function automatic logic [WIDTH-1:0] shift_lvl(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (op)
      OP_ROL: r = (d << sh) | (d >> (WIDTH - sh));
      OP_ROR: r = (d >> sh) | (d << (WIDTH - sh));
      OP_SLL: r = d << sh;
`ifdef BSH_SRA_EN
      OP_SRX: r = $signed(d) >>> sh;
`else
      OP_SRX: r = d >> sh;
`endif
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < LAT; k++) begin : g_sl
    logic               v_q;
    logic               v_i;
    logic               rdy;
    logic               rdy_n;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   d_i;
    logic [WIDTH-1:0]   d_n;
    logic [WIDTH-1:0]   x;
    logic [SHAMT_W-1:0] s_i;
    logic [SHAMT_W-1:0] b;
    logic [1:0]         o_i;
    logic [TAG_W-1:0]   t_q;
    logic [TAG_W-1:0]   t_i;

    if (k == 0) begin : g_src
      assign v_i = in_valid;
      assign d_i = in_data;
      assign s_i = in_shamt;
      assign o_i = in_op;
      assign t_i = in_tag;
    end else begin : g_src
      assign v_i = g_sl[k-1].v_q;
      assign d_i = g_sl[k-1].d_q;
      assign s_i = g_sl[k-1].g_fw.s_q;
      assign o_i = g_sl[k-1].g_fw.o_q;
      assign t_i = g_sl[k-1].t_q;
    end

    if (k == LAT - 1) begin : g_dn
      assign rdy_n = out_ready;
    end else begin : g_dn
      assign rdy_n = g_sl[k+1].rdy;
    end

    assign rdy = !v_q || rdy_n;

    // Levels beyond NLEV see shamt bits shifted out as zero.
    always_comb begin
      x = d_i;
      b = s_i >> (k * LEVELS_PER_STAGE);
      for (int j = 0; j < LEVELS_PER_STAGE; j++) begin
        if (b[0])
          x = shift_lvl(x, o_i,
                        1 << (k * LEVELS_PER_STAGE + j));
        b = b >> 1;
      end
      d_n = x;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
        t_q <= '0;
      end else if (rdy) begin
        v_q <= v_i;
        if (v_i) begin
          d_q <= d_n;
          t_q <= t_i;
        end
      end
    end

    // The final slice has no later levels to feed.
    if (k < LAT - 1) begin : g_fw
      logic [SHAMT_W-1:0] s_q;
      logic [1:0]         o_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s_q <= '0;
          o_q <= '0;
        end else if (rdy && v_i) begin
          s_q <= s_i;
          o_q <= o_i;
        end
      end
    end
  end

  assign in_ready  = g_sl[0].rdy && !rst;
  assign out_valid = g_sl[LAT-1].v_q;
  assign out_data  = g_sl[LAT-1].d_q;
  assign out_tag   = g_sl[LAT-1].t_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (LPS=1 and LPS=5 instances).
// Build option BSH_SRA_EN selects the arithmetic op 11 expectations.
module tb_pipelined_barrel_shifter;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_SRX = 2'b11;

`ifdef BSH_SRA_EN
  localparam logic [31:0] E_SR31 = 32'hFFFF_FFFF;
  localparam logic [31:0] E_SR4  = 32'hFF00_0000;
`else
  localparam logic [31:0] E_SR31 = 32'h0000_0001;
  localparam logic [31:0] E_SR4  = 32'h0F00_0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_tag;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(
    .WIDTH(32), .LEVELS_PER_STAGE(1), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  pipelined_barrel_shifter #(
    .WIDTH(32), .LEVELS_PER_STAGE(5), .TAG_W(4)
  ) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Bitwise reference: each result bit picked from its source position.
  function automatic logic [31:0] ref_shift(
    input logic [31:0] d, input int s, input logic [1:0] op);
    logic [31:0] r;
    logic        fill;
    r = '0;
`ifdef BSH_SRA_EN
    fill = d[31];
`else
    fill = 1'b0;
`endif
    for (int j = 0; j < 32; j++) begin
      case (op)
        OP_ROL:  r[(j + s) % 32] = d[j];
        OP_ROR:  r[j] = d[(j + s) % 32];
        OP_SLL:  r[j] = (j >= s) ? d[j - s] : 1'b0;
        default: r[j] = (j + s < 32) ? d[j + s] : fill;
      endcase
    end
    return r;
  endfunction

  task automatic run1(input string nm,
                      input logic [31:0] d,
                      input logic [4:0] s,
                      input logic [1:0] op,
                      input logic [3:0] t,
                      input logic [31:0] e,
                      output int lat);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    in_tag   = t;
    #1;
    while (!in_ready && w < 20) begin
      cyc;
      w++;
    end
    cyc;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc;
      lat++;
    end
    chk({nm, "_valid"}, 64'(out_valid), 64'(1));
    chk({nm, "_data"}, 64'(out_data), 64'(e));
    chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int sent;
    int got;
    int stall;
    int first;
    int last;
    int stalls;
    int seen;
    bit first_seen;
    bit saw_full;
    logic [31:0] cur_d;
    logic [4:0]  cur_s;
    logic [1:0]  cur_o;
    logic [35:0] exp_q[$];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    cyc;
    cyc;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'(1));
    chk("rel_out_valid", 64'(out_valid), 64'(0));
    chk("rel_out_data", 64'(out_data), 64'(0));
    chk("rel_out_tag", 64'(out_tag), 64'(0));

    run1("t1_rol", 32'h8000_0001, 5'd1, OP_ROL, 4'd3,
         32'h0000_0003, lat);
    chk("t1_latency", 64'(lat), 64'(5));

    run1("t2_ror", 32'h0000_0001, 5'd4, OP_ROR, 4'd1,
         32'h1000_0000, lat);
    run1("t2_sll", 32'hFFFF_FFFF, 5'd31, OP_SLL, 4'd2,
         32'h8000_0000, lat);
    run1("t2_sr31", 32'h8000_0000, 5'd31, OP_SRX, 4'd4,
         E_SR31, lat);
    run1("t2_sr4", 32'hF000_0000, 5'd4, OP_SRX, 4'd5,
         E_SR4, lat);
    run1("t2_rol8", 32'h1234_5678, 5'd8, OP_ROL, 4'd6,
         32'h3456_7812, lat);
    run1("t2_zero", 32'hDEAD_BEEF, 5'd0, OP_ROR, 4'd7,
         32'hDEAD_BEEF, lat);
    run1("t2_rol31", 32'h0000_0001, 5'd31, OP_ROL, 4'd8,
         32'h8000_0000, lat);

    // Stall the consumer for 3 cycles after the first result.
    sent = 0;
    got = 0;
    stall = 0;
    first_seen = 1'b0;
    saw_full = 1'b0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        stall = 3;
      end
      out_ready = (stall == 0);
      in_valid  = (sent < 8);
      in_data   = 32'h1;
      in_shamt  = 5'(sent);
      in_op     = OP_SLL;
      in_tag    = 4'(sent);
      #1;
      if (stall > 0) begin
        chk("t3_hold_valid", 64'(out_valid), 64'(1));
        chk("t3_hold_data", 64'(out_data), 64'(1));
        chk("t3_hold_tag", 64'(out_tag), 64'(0));
        stall--;
      end
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("t3_tag", 64'(out_tag), 64'(got));
        chk("t3_data", 64'(out_data), 64'(1) << got);
        got++;
      end
      cyc;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t3_in_ready_fell", 64'(saw_full), 64'(1));
    chk("t3_count", 64'(got), 64'(8));
    repeat (3) cyc;

    sent = 0;
    got = 0;
    first = -1;
    last = -1;
    stalls = 0;
    cur_d = $urandom;
    cur_s = 5'($urandom_range(0, 31));
    cur_o = 2'($urandom_range(0, 3));
    for (int c = 0; c < 600 && got < 200; c++) begin
      out_ready = 1'b1;
      in_valid  = (sent < 200);
      in_data   = cur_d;
      in_shamt  = cur_s;
      in_op     = cur_o;
      in_tag    = 4'(sent);
      #1;
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        exp_q.push_back({4'(sent),
                         ref_shift(cur_d, int'(cur_s), cur_o)});
        sent++;
        cur_d = $urandom;
        cur_s = 5'($urandom_range(0, 31));
        cur_o = 2'($urandom_range(0, 3));
      end
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        if (exp_q.size() == 0)
          chk("t4_extra", 64'(out_valid), 64'(0));
        else
          chk("t4_result", {28'b0, out_tag, out_data},
              {28'b0, exp_q.pop_front()});
        got++;
      end
      cyc;
    end
    in_valid = 1'b0;
    chk("t4_count", 64'(got), 64'(200));
    chk("t4_span", 64'(last - first), 64'(199));
    chk("t4_in_stalls", 64'(stalls), 64'(0));
    repeat (3) cyc;

    // Reset with three operands in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA5A5_0000 | 32'(i);
      in_shamt = 5'(i);
      in_op    = OP_ROL;
      in_tag   = 4'(8 + i);
      cyc;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", 64'(in_ready), 64'(0));
    cyc;
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      cyc;
    end
    chk("t5_stale", 64'(seen), 64'(0));

    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    in_shamt = 5'd31;
    in_op    = OP_ROL;
    in_tag   = 4'hC;
    #1;
    chk("t6_in_ready", 64'(b_in_ready), 64'(1));
    cyc;
    in_valid = 1'b0;
    chk("t6_valid", 64'(b_out_valid), 64'(1));
    chk("t6_data", 64'(b_out_data), 64'h8000_0000);
    chk("t6_tag", 64'(b_out_tag), 64'hC);
    cyc;
    chk("t6_drain", 64'(b_out_valid), 64'(0));
    repeat (6) cyc;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
